stopwatch_button_ctrl: RTL and testbench

- Front-panel control stage that sits directly upstream of the stopwatch counter/display block.
- Synchronises and debounces two raw pushbuttons: start/stop and clear.
- A run/pause/idle FSM produces two outputs:
  - the level `run`, which drives the stopwatch `start` input;
  - a one-cycle `clear_pulse`, which zeroes the stopwatch digits.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/button_debounce.sv | 69 ++++++
 rtl/stopwatch_button_ctrl.sv | 106 ++++++++++
 tb/tb_stopwatch_button_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-panel control stage:
// FSM state encoding, clock rate and the default debounce window.
package stopwatch_pkg;

    // System clock rate the debounce window is sized against.
    localparam int unsigned CLK_HZ = 50_000_000;

    // 10 ms of stable input at CLK_HZ before a button level is accepted.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;

    // Run/pause/idle FSM encoding, also exported on the status LEDs.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } sw_state_t;

    // True for the three encodings the FSM is allowed to occupy.
    function automatic logic is_legal_state(input logic [1:0] enc);
        logic legal;
        case (enc)
            2'b00:   legal = 1'b1;
            2'b01:   legal = 1'b1;
            2'b10:   legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton channel: 2-FF synchroniser, stable-level debounce counter
// and a single-cycle press strobe on each accepted rising level.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_r;
    logic             s2_r;
    logic             db_r;
    logic             db_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= btn;
            s2_r <= s1_r;
        end
    end

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive clocks; any shorter excursion restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_r  <= 1'b0;
            cnt_r <= CNT_ZERO;
        end else if (s2_r == db_r) begin
            db_r  <= db_r;
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
            db_r  <= s2_r;
            cnt_r <= CNT_ZERO;
        end else begin
            db_r  <= db_r;
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Registered rising-edge detect on the accepted level; release is silent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_q_r  <= 1'b0;
            press_r <= 1'b0;
        end else begin
            db_q_r  <= db_r;
            press_r <= db_r & ~db_q_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/stopwatch_button_ctrl.sv
// Front-panel control for the stopwatch: debounces start/stop and clear,
// then runs an idle/running/paused FSM that drives the stopwatch start level
// and a one-cycle digit-clear strobe.
module stopwatch_button_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic       run,
    output logic       clear_pulse,
    output logic [1:0] state
);

    logic      ss_press_s;
    logic      clr_press_s;
    sw_state_t state_r;
    logic      run_r;
    logic      clear_pulse_r;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_start_stop (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (btn_start_stop),
        .press   (ss_press_s)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (btn_clear),
        .press   (clr_press_s)
    );

    // Run/pause/idle FSM; start/stop has priority and swallows a coincident clear.
    // run is loaded alongside state so both move on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            run_r         <= 1'b0;
            clear_pulse_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ss_press_s) begin
                        state_r       <= ST_RUNNING;
                        run_r         <= 1'b1;
                        clear_pulse_r <= 1'b0;
                    end else if (clr_press_s) begin
                        state_r       <= ST_IDLE;
                        run_r         <= 1'b0;
                        clear_pulse_r <= 1'b1;
                    end else begin
                        state_r       <= ST_IDLE;
                        run_r         <= 1'b0;
                        clear_pulse_r <= 1'b0;
                    end
                end
                ST_RUNNING: begin
                    if (ss_press_s) begin
                        state_r       <= ST_PAUSED;
                        run_r         <= 1'b0;
                        clear_pulse_r <= 1'b0;
                    end else begin
                        state_r       <= ST_RUNNING;
                        run_r         <= 1'b1;
                        clear_pulse_r <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (ss_press_s) begin
                        state_r       <= ST_RUNNING;
                        run_r         <= 1'b1;
                        clear_pulse_r <= 1'b0;
                    end else if (clr_press_s) begin
                        state_r       <= ST_IDLE;
                        run_r         <= 1'b0;
                        clear_pulse_r <= 1'b1;
                    end else begin
                        state_r       <= ST_PAUSED;
                        run_r         <= 1'b0;
                        clear_pulse_r <= 1'b0;
                    end
                end
                default: begin
                    // Unused encoding 2'b11: fall back to a safe idle.
                    state_r       <= ST_IDLE;
                    run_r         <= 1'b0;
                    clear_pulse_r <= 1'b0;
                end
            endcase
        end
    end

    assign run         = run_r;
    assign clear_pulse = clear_pulse_r;
    assign state       = state_r;

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Directed bench for stopwatch_button_ctrl with a 4-cycle debounce window.
module tb_stopwatch_button_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       run;
    logic       clear_pulse;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_button_ctrl #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .run            (run),
        .clear_pulse    (clear_pulse),
        .state          (state)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drop both buttons and let the accepted levels return to 0; nothing may change.
    task automatic release_all(input logic [1:0] exp_state);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (state !== exp_state || clear_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL release: state=%b clear_pulse=%b, required state=%b clear_pulse=0", state, clear_pulse, exp_state);
            end
        end
    endtask

    // Assert buttons and stop just after edge 7 (one edge before the FSM reacts).
    task automatic press_to_edge7(input logic ss, input logic clr);
        btn_start_stop = ss;
        btn_clear      = clr;
        repeat (7) tick();
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            btn_start_stop = i[0];
            btn_clear      = i[1];
            tick();
            n_cmp++;
            if (run !== 1'b0 || clear_pulse !== 1'b0 || state !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_hold: run=%b clear_pulse=%b state=%b, required 0/0/00", run, clear_pulse, state);
            end
        end
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        reset_n        = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (run !== 1'b0 || clear_pulse !== 1'b0 || state !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release: run=%b clear_pulse=%b state=%b, required 0/0/00", run, clear_pulse, state);
        end
    endtask

    task automatic test_glitch;
        btn_start_stop = 1'b1;
        repeat (3) tick();
        btn_start_stop = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++;
            if (run !== 1'b0 || state !== 2'b00 || clear_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch: run=%b state=%b clear_pulse=%b, required 0/00/0", run, state, clear_pulse);
            end
        end
    endtask

    task automatic test_start_hold;
        btn_start_stop = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (run !== (k == 8) || state !== ((k == 8) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL start_latency edge %0d: run=%b state=%b, required run=%b", k, run, state, (k == 8));
            end
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++;
            if (run !== 1'b1 || state !== 2'b01 || clear_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL start_hold: run=%b state=%b clear_pulse=%b, required 1/01/0", run, state, clear_pulse);
            end
        end
        release_all(2'b01);
    endtask

    task automatic test_clear_running;
        btn_clear = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++;
            if (run !== 1'b1 || state !== 2'b01 || clear_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL clear_running: run=%b state=%b clear_pulse=%b, required 1/01/0", run, state, clear_pulse);
            end
        end
        release_all(2'b01);
    endtask

    task automatic test_pause;
        press_to_edge7(1'b1, 1'b0);
        n_cmp++;
        if (state !== 2'b01 || run !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_early: state=%b run=%b, required 01/1", state, run);
        end
        tick();
        n_cmp++;
        if (state !== 2'b10 || run !== 1'b0) begin
            n_bad++;
            $display("FAIL pause: state=%b run=%b, required 10/0", state, run);
        end
        release_all(2'b10);
    endtask

    task automatic test_clear_paused;
        press_to_edge7(1'b0, 1'b1);
        n_cmp++;
        if (state !== 2'b10 || clear_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_paused_early: state=%b clear_pulse=%b, required 10/0", state, clear_pulse);
        end
        tick();
        n_cmp++;
        if (state !== 2'b00 || clear_pulse !== 1'b1 || run !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_paused: state=%b clear_pulse=%b run=%b, required 00/1/0", state, clear_pulse, run);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (state !== 2'b00 || clear_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL clear_single: state=%b clear_pulse=%b, required 00/0", state, clear_pulse);
            end
        end
        release_all(2'b00);
    endtask

    task automatic test_clear_idle;
        press_to_edge7(1'b0, 1'b1);
        tick();
        n_cmp++;
        if (state !== 2'b00 || clear_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_idle: state=%b clear_pulse=%b, required 00/1", state, clear_pulse);
        end
        tick();
        n_cmp++;
        if (clear_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_idle_end: clear_pulse=%b, required 0", clear_pulse);
        end
        release_all(2'b00);
    endtask

    task automatic test_simultaneous;
        press_to_edge7(1'b1, 1'b0);
        tick();
        release_all(2'b01);
        press_to_edge7(1'b1, 1'b0);
        tick();
        n_cmp++;
        if (state !== 2'b10) begin
            n_bad++;
            $display("FAIL both_setup: state=%b, required 10", state);
        end
        release_all(2'b10);
        btn_start_stop = 1'b1;
        btn_clear      = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            n_cmp++;
            if (clear_pulse !== 1'b0 || state !== ((k >= 8) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL both edge %0d: state=%b clear_pulse=%b", k, state, clear_pulse);
            end
        end
        release_all(2'b01);
    endtask

    task automatic test_reset_mid;
        btn_start_stop = 1'b1;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (run !== 1'b0 || state !== 2'b00 || clear_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: run=%b state=%b clear_pulse=%b, required 0/00/0", run, state, clear_pulse);
        end
        btn_start_stop = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        btn_start_stop = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (run !== (k == 8) || state !== ((k == 8) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL reset_repress edge %0d: run=%b state=%b, required run=%b", k, run, state, (k == 8));
            end
        end
        release_all(2'b01);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start_hold();
        test_clear_running();
        test_pause();
        test_clear_paused();
        test_clear_idle();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
